// File: rtl/sig_accum_pkg.sv
// sig_accum shared types: FSM state encoding and the
// rotate-left-1 XOR fold used to build the signature.
package sig_accum_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    ACCUM,
    DONE
  } state_t;

  // Widest signature the fold helper supports.
  localparam int FOLD_W = 64;
  localparam int IDX_W  = $clog2(FOLD_W);

  // Rotates the low w bits of s left by one, then XORs in d.
  // Bits at and above w stay zero, so callers zero-extend
  // both operands and read back the low w bits.
  function automatic logic [FOLD_W-1:0] fold(
    input logic [FOLD_W-1:0] s,
    input logic [FOLD_W-1:0] d,
    input int                w
  );
    logic [FOLD_W-1:0] r;
    r = '0;
    for (int i = 1; i < FOLD_W; i++) begin
      if (i < w) r[IDX_W'(i)] = s[IDX_W'(i - 1)];
    end
    r[0] = s[IDX_W'(w - 1)];
    return r ^ d;
  endfunction

endpackage

// File: rtl/sig_accum.sv
// sig_accum: drops SKIP beats, folds LEN beats into a signature.
// Ports: clk, rst_n, start, in_valid/in_data/in_ready, busy, done, pass, sig.
module sig_accum
  import sig_accum_pkg::*;
#(
  parameter int              DATA_W = 9,
  parameter int              SIG_W  = 32,
  parameter int              SKIP   = 10,
  parameter int              LEN    = 79,
  parameter logic [SIG_W-1:0] EXPECT = 32'he8bbd130
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  sig
);

  localparam int CNT_MAX = (SKIP > LEN) ? SKIP : LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state;
  state_t            nxt;
  logic [CNT_W-1:0]  skip_cnt;
  logic [CNT_W-1:0]  acc_cnt;
  logic              beat;
  logic              go;
  logic              skip_last;
  logic              acc_last;
  logic [FOLD_W-1:0] fnext;
  logic              hit;

  // Ready comes purely from the state register.
  assign in_ready = (state == sig_accum_pkg::SKIP)
                 || (state == ACCUM);
  assign busy     = in_ready;
  assign done     = (state == DONE);

  assign beat      = in_valid & in_ready;
  assign go        = start & ~in_ready;
  assign skip_last = (skip_cnt == CNT_W'(1));
  assign acc_last  = (acc_cnt == CNT_W'(1));

  assign fnext = fold(FOLD_W'(sig), FOLD_W'(in_data), SIG_W);
  assign hit   = (fnext == FOLD_W'(EXPECT));

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          nxt = (SKIP == 0) ? ACCUM : sig_accum_pkg::SKIP;
        end
      end
      sig_accum_pkg::SKIP: begin
        if (beat && skip_last) nxt = ACCUM;
      end
      ACCUM: begin
        if (beat && acc_last) nxt = DONE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sig      <= '0;
      pass     <= 1'b0;
      skip_cnt <= '0;
      acc_cnt  <= '0;
    end else begin
      state <= nxt;
      if (go) begin
        sig      <= '0;
        pass     <= 1'b0;
        skip_cnt <= CNT_W'(SKIP);
        acc_cnt  <= CNT_W'(LEN);
      end else if (beat) begin
        if (state == sig_accum_pkg::SKIP) begin
          skip_cnt <= skip_cnt - CNT_W'(1);
        end else begin
          sig     <= fnext[SIG_W-1:0];
          acc_cnt <= acc_cnt - CNT_W'(1);
          if (acc_last) pass <= hit;
        end
      end
    end
  end

endmodule

// File: tb/tb_sig_accum.sv
// Directed bench for sig_accum over several parameter sets.
// Instances share in_valid/in_data; each has its own start.
module tb_sig_accum;

  logic        clk;
  logic        rst_n;
  logic        vld;
  logic [8:0]  dat;
  logic [5:0]  st;
  logic [5:0]  rdy;
  logic [5:0]  bsy;
  logic [5:0]  dn;
  logic [5:0]  ps;
  logic [31:0] sg [6];

  int cc;
  int ec;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sig_accum #(.SKIP(0), .LEN(1), .EXPECT(32'h1FF)) u_a (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .in_valid(vld),
    .in_data(dat), .in_ready(rdy[0]), .busy(bsy[0]),
    .done(dn[0]), .pass(ps[0]), .sig(sg[0]));

  sig_accum #(.SKIP(0), .LEN(2), .EXPECT(32'h2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .in_valid(vld),
    .in_data(dat), .in_ready(rdy[1]), .busy(bsy[1]),
    .done(dn[1]), .pass(ps[1]), .sig(sg[1]));

  sig_accum #(.SKIP(0), .LEN(2), .EXPECT(32'h0)) u_c (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .in_valid(vld),
    .in_data(dat), .in_ready(rdy[2]), .busy(bsy[2]),
    .done(dn[2]), .pass(ps[2]), .sig(sg[2]));

  sig_accum #(.SKIP(0), .LEN(33), .EXPECT(32'h1)) u_d (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .in_valid(vld),
    .in_data(dat), .in_ready(rdy[3]), .busy(bsy[3]),
    .done(dn[3]), .pass(ps[3]), .sig(sg[3]));

  sig_accum #(.SKIP(2), .LEN(1), .EXPECT(32'h3)) u_e (
    .clk(clk), .rst_n(rst_n), .start(st[4]), .in_valid(vld),
    .in_data(dat), .in_ready(rdy[4]), .busy(bsy[4]),
    .done(dn[4]), .pass(ps[4]), .sig(sg[4]));

  sig_accum u_f (
    .clk(clk), .rst_n(rst_n), .start(st[5]), .in_valid(vld),
    .in_data(dat), .in_ready(rdy[5]), .busy(bsy[5]),
    .done(dn[5]), .pass(ps[5]), .sig(sg[5]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [5:0] m);
    st = m;
    tick();
    st = '0;
  endtask

  task automatic beat(input logic [8:0] d);
    vld = 1'b1;
    dat = d;
    tick();
    vld = 1'b0;
    dat = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 6; i++) begin
      cc++;
      if ({rdy[i], bsy[i], dn[i], ps[i], sg[i]} !== 36'h0) begin
        ec++;
        $display("FAIL reset[%0d] got %h want 0", i,
                 {rdy[i], bsy[i], dn[i], ps[i], sg[i]});
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    pulse(6'b000001);
    cc++;
    if ({rdy[0], bsy[0], dn[0], sg[0]} !== {3'b110, 32'h0}) begin
      ec++;
      $display("FAIL single_start got %h want %h",
               {rdy[0], bsy[0], dn[0], sg[0]}, {3'b110, 32'h0});
    end
    beat(9'h1FF);
    cc++;
    if ({dn[0], ps[0], bsy[0], rdy[0], sg[0]} !== {4'b1100, 32'h1FF}) begin
      ec++;
      $display("FAIL single_done got %h want %h",
               {dn[0], ps[0], bsy[0], rdy[0], sg[0]}, {4'b1100, 32'h1FF});
    end
  endtask

  task automatic test_pass_fail();
    pulse(6'b000110);
    beat(9'h001);
    cc++;
    if ({dn[1], sg[1]} !== {1'b0, 32'h1}) begin
      ec++;
      $display("FAIL pf_mid got %h want %h", {dn[1], sg[1]}, {1'b0, 32'h1});
    end
    beat(9'h000);
    cc++;
    if ({dn[1], ps[1], sg[1]} !== {2'b11, 32'h2}) begin
      ec++;
      $display("FAIL pf_pass got %h want %h",
               {dn[1], ps[1], sg[1]}, {2'b11, 32'h2});
    end
    cc++;
    if ({dn[2], ps[2], sg[2]} !== {2'b10, 32'h2}) begin
      ec++;
      $display("FAIL pf_fail got %h want %h",
               {dn[2], ps[2], sg[2]}, {2'b10, 32'h2});
    end
  endtask

  task automatic test_wrap();
    pulse(6'b001000);
    beat(9'h001);
    repeat (31) beat(9'h000);
    cc++;
    if ({dn[3], sg[3]} !== {1'b0, 32'h8000_0000}) begin
      ec++;
      $display("FAIL wrap_msb got %h want %h",
               {dn[3], sg[3]}, {1'b0, 32'h8000_0000});
    end
    beat(9'h000);
    cc++;
    if ({dn[3], ps[3], sg[3]} !== {2'b11, 32'h1}) begin
      ec++;
      $display("FAIL wrap_lsb got %h want %h",
               {dn[3], ps[3], sg[3]}, {2'b11, 32'h1});
    end
  endtask

  task automatic test_skip();
    pulse(6'b010000);
    beat(9'h0AA);
    beat(9'h055);
    cc++;
    if ({bsy[4], dn[4], sg[4]} !== {2'b10, 32'h0}) begin
      ec++;
      $display("FAIL skip_mid got %h want %h",
               {bsy[4], dn[4], sg[4]}, {2'b10, 32'h0});
    end
    beat(9'h003);
    cc++;
    if ({dn[4], ps[4], sg[4]} !== {2'b11, 32'h3}) begin
      ec++;
      $display("FAIL skip_done got %h want %h",
               {dn[4], ps[4], sg[4]}, {2'b11, 32'h3});
    end
  endtask

  task automatic test_backpressure();
    pulse(6'b010000);
    cc++;
    if ({dn[4], ps[4], sg[4]} !== {2'b00, 32'h0}) begin
      ec++;
      $display("FAIL bp_restart got %h want %h",
               {dn[4], ps[4], sg[4]}, {2'b00, 32'h0});
    end
    beat(9'h0AA);
    repeat (3) tick();
    beat(9'h055);
    repeat (3) tick();
    cc++;
    if ({dn[4], bsy[4], sg[4]} !== {2'b01, 32'h0}) begin
      ec++;
      $display("FAIL bp_stall got %h want %h",
               {dn[4], bsy[4], sg[4]}, {2'b01, 32'h0});
    end
    beat(9'h003);
    cc++;
    if ({dn[4], ps[4], sg[4]} !== {2'b11, 32'h3}) begin
      ec++;
      $display("FAIL bp_done got %h want %h",
               {dn[4], ps[4], sg[4]}, {2'b11, 32'h3});
    end
  endtask

  task automatic test_start_with_beat();
    st  = 6'b000001;
    vld = 1'b1;
    dat = 9'h00F;
    tick();
    st  = '0;
    vld = 1'b0;
    cc++;
    if ({dn[0], rdy[0], sg[0]} !== {2'b01, 32'h0}) begin
      ec++;
      $display("FAIL swb_start got %h want %h",
               {dn[0], rdy[0], sg[0]}, {2'b01, 32'h0});
    end
    beat(9'h1FF);
    cc++;
    if ({dn[0], ps[0], sg[0]} !== {2'b11, 32'h1FF}) begin
      ec++;
      $display("FAIL swb_done got %h want %h",
               {dn[0], ps[0], sg[0]}, {2'b11, 32'h1FF});
    end
  endtask

  task automatic test_defaults();
    pulse(6'b100000);
    repeat (10) beat(9'h000);
    beat(9'h001);
    cc++;
    if (sg[5] !== 32'h1) begin
      ec++;
      $display("FAIL def_first got %h want %h", sg[5], 32'h1);
    end
    pulse(6'b100000);
    cc++;
    if ({bsy[5], sg[5]} !== {1'b1, 32'h1}) begin
      ec++;
      $display("FAIL def_busy_start got %h want %h",
               {bsy[5], sg[5]}, {1'b1, 32'h1});
    end
    repeat (77) beat(9'h000);
    cc++;
    if ({dn[5], sg[5]} !== {1'b0, 32'h2000}) begin
      ec++;
      $display("FAIL def_88 got %h want %h",
               {dn[5], sg[5]}, {1'b0, 32'h2000});
    end
    beat(9'h000);
    cc++;
    if ({dn[5], ps[5], bsy[5], sg[5]} !== {3'b100, 32'h4000}) begin
      ec++;
      $display("FAIL def_89 got %h want %h",
               {dn[5], ps[5], bsy[5], sg[5]}, {3'b100, 32'h4000});
    end
  endtask

  task automatic test_reset_mid();
    pulse(6'b100000);
    repeat (10) beat(9'h000);
    beat(9'h1FF);
    beat(9'h000);
    cc++;
    if ({bsy[5], sg[5]} !== {1'b1, 32'h3FE}) begin
      ec++;
      $display("FAIL rm_pre got %h want %h",
               {bsy[5], sg[5]}, {1'b1, 32'h3FE});
    end
    #2;
    rst_n = 1'b0;
    #1;
    cc++;
    if ({rdy[5], bsy[5], dn[5], ps[5], sg[5]} !== 36'h0) begin
      ec++;
      $display("FAIL rm_async got %h want 0",
               {rdy[5], bsy[5], dn[5], ps[5], sg[5]});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    beat(9'h1FF);
    cc++;
    if ({rdy[5], bsy[5], dn[5], ps[5], sg[5]} !== 36'h0) begin
      ec++;
      $display("FAIL rm_idle got %h want 0",
               {rdy[5], bsy[5], dn[5], ps[5], sg[5]});
    end
  endtask

  initial begin
    cc    = 0;
    ec    = 0;
    rst_n = 1'b0;
    st    = '0;
    vld   = 1'b0;
    dat   = '0;
    test_reset();
    test_single();
    test_pass_fail();
    test_wrap();
    test_skip();
    test_backpressure();
    test_start_with_beat();
    test_defaults();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", cc, ec);
    $finish;
  end

endmodule
